// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// opcodes and the select/ALU codes driven onto the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_mainfsm.sv
// Main Moore FSM of the multicycle controller. With MULTICYCLE_CTRL_DBG_EN
// defined, the raw state encoding is exported on state_DBG.
module mc_mainfsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output logic [1:0] ALUOp,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       illegal_op,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB
`ifdef MULTICYCLE_CTRL_DBG_EN
    ,
    output logic [3:0] state_DBG
`endif
);

    state_t state, state_nxt;
    logic   irwrite_raw, regwrite_raw, memwrite_raw;
    logic   pcupdate_raw, branch_raw, illegal_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // Next state and Moore outputs; anything a state does not name stays 0.
    always_comb begin
        state_nxt    = FETCH;
        ALUOp        = ALUOP_ADD;
        AdrSrc       = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RD2;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        pcupdate_raw = 1'b0;
        branch_raw   = 1'b0;
        illegal_raw  = 1'b0;
        case (state)
            FETCH: begin
                irwrite_raw  = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
                pcupdate_raw = 1'b1;
                state_nxt    = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTER;
                    OP_ITYPE:     state_nxt = EXECUTEI;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_JAL:       state_nxt = JAL;
                    default: begin
                        state_nxt   = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc    = RES_DATA;
                regwrite_raw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA   = SRCA_RD1;
                ALUOp     = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                regwrite_raw = 1'b1;
            end
            JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                pcupdate_raw = 1'b1;
                state_nxt    = ALUWB;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALUOP_SUB;
                branch_raw = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Reset forces FETCH, whose outputs would otherwise fire IRWrite/PC update.
    assign IRWrite    = irwrite_raw  & ~reset;
    assign RegWrite   = regwrite_raw & ~reset;
    assign MemWrite   = memwrite_raw & ~reset;
    assign PCUpdate   = pcupdate_raw & ~reset;
    assign Branch     = branch_raw   & ~reset;
    assign illegal_op = illegal_raw  & ~reset;

`ifdef MULTICYCLE_CTRL_DBG_EN
    assign state_DBG = state;
`endif

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control unit: main FSM plus ImmSrc/ALU decoders.
// Defining MULTICYCLE_CTRL_DBG_EN adds the state_DBG/ALUOp_DBG ports.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl
`ifdef MULTICYCLE_CTRL_DBG_EN
    ,
    output logic [3:0] state_DBG,
    output logic [1:0] ALUOp_DBG
`else
`endif
);

    logic [1:0] aluop;
    logic       pcupdate, branch;

    mc_mainfsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .ALUOp      (aluop),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .PCUpdate   (pcupdate),
        .Branch     (branch),
        .illegal_op (illegal_op),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB)
`ifdef MULTICYCLE_CTRL_DBG_EN
        ,
        .state_DBG  (state_DBG)
`endif
    );

`ifdef MULTICYCLE_CTRL_DBG_EN
    assign ALUOp_DBG = aluop;
`endif

    assign PCWrite = pcupdate | (branch & Zero);

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // Only R-type (op[5]=1) with funct7b5 turns funct3=000 into subtract.
    always_comb begin
        ALUControl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected
// output vectors, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic       ill;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [2:0] aluc;
    } outv_t;

    typedef enum int {KLW, KSW, KR, KI, KBEQ, KJAL, KILL} kind_t;

    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
    localparam int SER = 6, SWB = 7, SEI = 8, SJ = 9, SB = 10, SILLD = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
`ifdef MULTICYCLE_CTRL_DBG_EN
    logic [3:0] state_DBG;
    logic [1:0] ALUOp_DBG;
`endif

    outv_t actual;
    outv_t expQ[$];
    string nameQ[$];
    int    vectors = 0;
    int    miscompares = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
`ifdef MULTICYCLE_CTRL_DBG_EN
        ,
        .state_DBG  (state_DBG),
        .ALUOp_DBG  (ALUOp_DBG)
`endif
    );

    always #5 clk = ~clk;

    assign actual = '{pcw: PCWrite, adr: AdrSrc, memw: MemWrite, irw: IRWrite,
                      regw: RegWrite, ill: illegal_op, res: ResultSrc,
                      srca: ALUSrcA, srcb: ALUSrcB, imm: ImmSrc, aluc: ALUControl};

    task automatic checkOutput(input string nm, input outv_t got, input outv_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(nameQ.pop_front(), actual, expQ.pop_front());
    end

    // Hand-tabulated per-state outputs; imm and the funct-decoded ALU code are
    // given per instruction since they depend on op/funct fields.
    function automatic outv_t stVec(input int s, input logic [1:0] imm,
                                    input logic [2:0] aexec, input logic zero);
        outv_t v = '0;
        v.imm = imm;
        case (s)
            SF:    begin v.pcw = 1; v.irw = 1; v.res = 2'b10; v.srcb = 2'b10; end
            SD:    begin v.srca = 2'b01; v.srcb = 2'b01; end
            SILLD: begin v.srca = 2'b01; v.srcb = 2'b01; v.ill = 1; end
            SMA:   begin v.srca = 2'b10; v.srcb = 2'b01; end
            SMR:   begin v.adr = 1; end
            SMWB:  begin v.res = 2'b01; v.regw = 1; end
            SMW:   begin v.adr = 1; v.memw = 1; end
            SER:   begin v.srca = 2'b10; v.aluc = aexec; end
            SEI:   begin v.srca = 2'b10; v.srcb = 2'b01; v.aluc = aexec; end
            SWB:   begin v.regw = 1; end
            SJ:    begin v.pcw = 1; v.srca = 2'b01; v.srcb = 2'b10; end
            SB:    begin v.pcw = zero; v.srca = 2'b10; v.aluc = 3'b001; end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic outv_t resetVec(input logic [1:0] imm);
        outv_t v = '0;
        v.res  = 2'b10;
        v.srcb = 2'b10;
        v.imm  = imm;
        return v;
    endfunction

    // Called at posedge+1 while the DUT sits in FETCH; returns at the posedge+1
    // on which the next FETCH begins.
    task automatic applyStimulus(input string nm, input kind_t k, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7, input logic z,
                                 input logic [1:0] imm, input logic [2:0] aexec);
        int seq[$];
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        case (k)
            KLW:  seq = '{SF, SD, SMA, SMR, SMWB};
            KSW:  seq = '{SF, SD, SMA, SMW};
            KR:   seq = '{SF, SD, SER, SWB};
            KI:   seq = '{SF, SD, SEI, SWB};
            KBEQ: seq = '{SF, SD, SB};
            KJAL: seq = '{SF, SD, SJ, SWB};
            default: seq = '{SF, SILLD};
        endcase
        foreach (seq[i]) begin
            expQ.push_back(stVec(seq[i], imm, aexec, z));
            nameQ.push_back($sformatf("%s.c%0d", nm, i));
        end
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(resetVec(2'b00));
            nameQ.push_back($sformatf("reset.c%0d", i));
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus("lw",       KLW,  7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);
        applyStimulus("sw",       KSW,  7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000);
        applyStimulus("add",      KR,   7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000);
        applyStimulus("sub",      KR,   7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001);
        applyStimulus("addi_f7",  KI,   7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000);
        applyStimulus("slt",      KR,   7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101);
        applyStimulus("ori",      KI,   7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011);
        applyStimulus("and",      KR,   7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010);
        applyStimulus("r_f3_001", KR,   7'b0110011, 3'b001, 1'b1, 1'b0, 2'b00, 3'b000);
        applyStimulus("beq_z1",   KBEQ, 7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000);
        applyStimulus("beq_z0",   KBEQ, 7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b000);
        applyStimulus("jal",      KJAL, 7'b1101111, 3'b000, 1'b0, 1'b1, 2'b11, 3'b000);
        applyStimulus("illegal",  KILL, 7'b1111111, 3'b000, 1'b0, 1'b1, 2'b00, 3'b000);
        applyStimulus("lw2",      KLW,  7'b0000011, 3'b010, 1'b0, 1'b1, 2'b00, 3'b000);

        // sw interrupted by an asynchronous reset in the middle of MEMWRITE
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        expQ.push_back(stVec(SF,  2'b01, 3'b000, 1'b0)); nameQ.push_back("swrst.c0");
        expQ.push_back(stVec(SD,  2'b01, 3'b000, 1'b0)); nameQ.push_back("swrst.c1");
        expQ.push_back(stVec(SMA, 2'b01, 3'b000, 1'b0)); nameQ.push_back("swrst.c2");
        expQ.push_back(stVec(SMW, 2'b01, 3'b000, 1'b0)); nameQ.push_back("swrst.c3");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("swrst.immediate", actual, resetVec(2'b01));
        expQ.push_back(resetVec(2'b01)); nameQ.push_back("swrst.hold0");
        expQ.push_back(resetVec(2'b01)); nameQ.push_back("swrst.hold1");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus("lw_after", KLW,  7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000);
        applyStimulus("beq_end",  KBEQ, 7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b000);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
